// File: rtl/nibble_serial_adder_pkg.sv
// nsa_pkg: shared state type, slice width and index-width helper for the nibble-serial adder
package nsa_pkg;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_e;
  localparam int NIBBLE_W = 4;
  function automatic int idx_w(input int nibbles);
    return nibbles > 1 ? $clog2(nibbles) : 1;
  endfunction
endpackage

// File: rtl/nibble_serial_adder_add.sv
// nibble_add: combinational 4-bit ripple slice with carry in/out
module nibble_add
  import nsa_pkg::*;
(
  input  logic [NIBBLE_W-1:0] x,
  input  logic [NIBBLE_W-1:0] y,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] sum,
  output logic                co
);
  assign {co, sum} = (NIBBLE_W+1)'(x) + (NIBBLE_W+1)'(y) + (NIBBLE_W+1)'(ci);
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: W-bit adder that reuses one 4-bit slice, one nibble per cycle, LSB first
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = NIBBLE_W * NIBBLES,
  localparam int IW      = idx_w(NIBBLES)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] s,
  output logic         c_out
);
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic carry_q, carry_d, cout_q, cout_d, co;
  logic [NIBBLE_W-1:0] x, y, sum;
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign s         = s_q;
  assign c_out     = cout_q;
  always_comb begin
    x = '0;
    y = '0;
    for (int i = 0; i < NIBBLES; i++)
      if (idx_q == IW'(i)) begin
        x = a_q[i*NIBBLE_W +: NIBBLE_W];
        y = b_q[i*NIBBLE_W +: NIBBLE_W];
      end
  end
  nibble_add u_add (.x(x), .y(y), .ci(carry_q), .sum(sum), .co(co));
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    s_d     = s_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        a_d     = a;
        b_d     = b;
        carry_d = c_in;
        idx_d   = '0;
        state_d = ADD;
      end
      ADD: begin
        for (int i = 0; i < NIBBLES; i++)
          if (idx_q == IW'(i)) s_d[i*NIBBLE_W +: NIBBLE_W] = sum;
        carry_d = co;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IW'(NIBBLES-1)) begin
          cout_d  = co;
          state_d = DONE;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // c_out has its own register so it holds after handoff even when a new c_in is captured
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      s_q     <= s_d;
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: scoreboard bench with directed and random operands for NIBBLES=4, 1 and 8
module tb_nibble_serial_adder;
  localparam int N = 4;
  localparam int W = 4 * N;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1, c_in = 0;
  logic in_ready, out_valid, c_out;
  logic [W-1:0] a = '0, b = '0, s;
  logic [W:0] exp_q[$];
  int n_cmp = 0, n_err = 0;
  logic main_done = 0;
  always #5 clk = ~clk;
  nibble_serial_adder #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .c_in(c_in),
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .c_out(c_out)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    return {1'b0, x} + {1'b0, y} + (W+1)'(ci);
  endfunction
  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
      else chk("result", {c_out, s}, exp_q.pop_front());
    end
  task automatic reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_s"}, s, 0);
    chk({tag, "_c_out"}, c_out, 0);
  endtask
  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input int hold,
                    input bit check_lat);
    int t;
    logic [W:0] held;
    t = 0;
    while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
    if (!in_ready) chk("wait_in_ready", 0, 1);
    out_ready = hold == 0;
    in_valid = 1; a = x; b = y; c_in = ci;
    exp_q.push_back(model(x, y, ci));
    @(posedge clk); #1;
    in_valid = 0; a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
    t = 0;
    while (!out_valid && t < 50) begin @(posedge clk); #1; t++; end
    if (!out_valid) chk("result_timeout", 0, 1);
    if (check_lat) chk("latency", t, N);
    if (hold > 0) begin
      held = exp_q[0];
      for (int i = 0; i < hold; i++) begin
        in_valid = i[0]; a = W'($urandom);
        @(posedge clk); #1;
        chk("hold_valid", out_valid, 1);
        chk("hold_data", {c_out, s}, held);
        chk("hold_in_ready", in_ready, 0);
      end
      in_valid = 0; out_ready = 1;
      @(posedge clk); #1;
      chk("handoff_out_valid", out_valid, 0);
      chk("handoff_in_ready", in_ready, 1);
    end else begin
      @(posedge clk); #1;
    end
  endtask
  initial begin
    time t0;
    repeat (2) @(posedge clk);
    #1 reset_vals("reset");
    rst_n = 1;
    @(posedge clk); #1;
    op(16'h0000, 16'h0000, 0, 0, 1);
    op(16'h1234, 16'h4321, 0, 0, 1);
    op(16'h000F, 16'h0001, 0, 0, 1);
    op(16'hFFFF, 16'h0001, 0, 0, 1);
    op(16'hFFFF, 16'h0000, 1, 0, 1);
    op(16'hA5A5, 16'h5A5A, 0, 3, 1);
    // abort after two nibbles of an add; the prior 0xFFFF result makes the clear observable
    in_valid = 1; a = 16'h1234; b = 16'h1111; c_in = 0;
    @(posedge clk); #1 in_valid = 0;
    repeat (2) begin @(posedge clk); #1; end
    chk("add_in_ready", in_ready, 0);
    #2 rst_n = 0;
    #1 reset_vals("abort");
    @(posedge clk); #1 rst_n = 1;
    op(16'h0001, 16'h0001, 0, 0, 1);
    t0 = $time;
    repeat (5) op(W'($urandom), W'($urandom), 1'($urandom), 0, 0);
    chk("throughput_cycles", ($time - t0) / 10, 5 * (N + 2));
    repeat (30) op(W'($urandom), W'($urandom), 1'($urandom), 0, 0);
    chk("main_drain", exp_q.size(), 0);
    main_done = 1;
  end
  for (genvar g = 0; g < 2; g++) begin : gx
    localparam int NN = g == 0 ? 1 : 8;
    localparam int WW = 4 * NN;
    logic iv = 0, xc = 0, ir, ov, xco, done = 0;
    logic [WW-1:0] xa = '0, xb = '0, xs;
    logic [WW:0] q[$], e;
    nibble_serial_adder #(.NIBBLES(NN)) u (
      .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .a(xa), .b(xb), .c_in(xc),
      .out_valid(ov), .out_ready(1'b1), .s(xs), .c_out(xco)
    );
    always @(negedge clk)
      if (rst_n && ov) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL gen%0d_unexpected: got %0h, expected none", NN, {xco, xs});
        end else begin
          e = q.pop_front();
          if ({xco, xs} !== e) begin
            n_err++;
            $display("FAIL gen%0d_result: got %0h, expected %0h", NN, {xco, xs}, e);
          end
        end
      end
    initial begin
      int t;
      wait (main_done);
      @(posedge clk); #1;
      for (int k = 0; k < 40; k++) begin
        t = 0;
        while (!ir && t < 50) begin @(posedge clk); #1; t++; end
        iv = 1;
        xa = k == 0 ? '1 : WW'($urandom);
        xb = k == 0 ? '0 : WW'($urandom);
        xc = k == 0 ? 1'b1 : 1'($urandom);
        q.push_back({1'b0, xa} + {1'b0, xb} + (WW+1)'(xc));
        @(posedge clk); #1 iv = 0;
      end
      t = 0;
      while (q.size() != 0 && t < 100) begin @(posedge clk); #1; t++; end
      if (q.size() != 0) begin
        n_cmp++; n_err++;
        $display("FAIL gen%0d_drain: %0d outstanding, expected 0", NN, q.size());
      end
      done = 1;
    end
  end
  initial begin
    wait (main_done && gx[0].done && gx[1].done);
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle wide adder that adds two W-bit operands four bits per cycle through one 4-bit ripple slice, carrying between nibbles in a register. It sits directly upstream of the sum consumers and reuses the 4-bit adder function already in the design as its datapath. Operands enter and results leave on valid/ready handshakes, so area stays at one 4-bit slice regardless of word width.

## Interface
- NIBBLES, default 4: number of 4-bit digits per operand. W = 4*NIBBLES. Legal range 1..16.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair on a/b/c_in is valid.
- in_ready  output  1  block can accept operands.
- a  input  W  operand A.
- b  input  W  operand B.
- c_in  input  1  carry into nibble 0.
- out_valid  output  1  s/c_out hold a finished result.
- out_ready  input  1  consumer takes the result.
- s  output  W  sum, (a + b + c_in) mod 2^W.
- c_out  output  1  carry out of the top nibble.

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, capture a, b and c_in into the operand and carry registers, clear the nibble index to 0, and go to ADD.
  - ADD: each cycle, the slice adds nibble idx of A, nibble idx of B and the carry register. The 4-bit result is written to s[4*idx+3:4*idx], the slice carry-out goes to the carry register, and idx increments. After idx = NIBBLES-1, go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Nibbles are processed LSB first. The carry register is 1 bit. No sign handling: unsigned modulo-2^W arithmetic.
- c_out is the carry register value after the last nibble.
- Captured operands are stable for the whole computation. Changes on a/b/c_in after acceptance have no effect.
- in_ready is low in ADD and DONE. An in_valid seen then is ignored, not queued.
- When in_ready is low, the upstream must hold its request and operands until accepted. The block does not check this.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE, in_ready=1, out_valid=0, s=0, c_out=0, idx=0, carry register=0, operand registers=0.
- Latency: operands accepted at rising edge k; out_valid rises after edge k+NIBBLES.
- Throughput: one result per NIBBLES+2 cycles when out_ready is held high (accept, NIBBLES adds, handoff).
- s and c_out are registered and hold their value while out_valid=1, whatever out_ready does. After the handoff they keep their value until the next ADD overwrites them.
- The handoff edge (DONE with out_ready=1) moves to IDLE. in_ready rises in the following cycle; there is no same-cycle bypass.
- out_ready seen in IDLE or ADD is ignored.
- Reset asserted during ADD or DONE: the current operation is aborted, nothing is output, and all registers return to their reset values immediately.
- NIBBLES=1: ADD lasts exactly one cycle.

## Structure
- Shared package nsa_pkg:
  - state enum {IDLE, ADD, DONE};
  - constant NIBBLE_W=4;
  - function for the idx width, $clog2(NIBBLES) with a minimum of 1.
- Sub-module nibble_add: a combinational 4-bit slice with inputs x[3:0], y[3:0], ci and outputs sum[3:0], co. Instantiate it once.
- Top level: FSM, idx counter, operand registers, carry register and result register.

## Test plan
- Reset, then 0x0000 + 0x0000, c_in=0 -> s=0x0000, c_out=0, out_valid high exactly 4 cycles after acceptance.
- 0x1234 + 0x4321, c_in=0 -> s=0x5555, c_out=0. 0x000F + 0x0001 -> s=0x0010 (inter-nibble carry).
- 0xFFFF + 0x0001, c_in=0 -> s=0x0000, c_out=1. 0xFFFF + 0x0000, c_in=1 -> same result (carry propagates through all nibbles).
- out_ready low for 3 cycles in DONE with 0xA5A5 + 0x5A5A -> s=0xFFFF and out_valid stay stable. in_ready stays low while in_valid is toggled. The result is released on the first out_ready; in_ready rises one cycle later.
- rst_n pulsed low mid-ADD (after 2 nibbles) -> asynchronous clear of all outputs. After release, a new 0x0001 + 0x0001 yields s=0x0002.
- Back-to-back random operands with out_ready=1, checked against a + b + c_in; repeat with NIBBLES=1 and NIBBLES=8.
